sha256_mem_arbiter: RTL and testbench
=====================================

Name: sha256_mem_arbiter

Overview:
- Shares one word-addressed message/hash memory port between NUM_REQ SHA-256 engines.
- Engines read 512-bit message blocks and write back the 8-word digest through this port.
- Round-robin arbitration with burst locking, so a block fetch (16 words) or digest write (8 words) completes without interleaving.
- Read data is returned tagged to the requester that issued the read, after a fixed memory latency.

Parameters:
- NUM_REQ, 4, number of requesting SHA-256 engines (2..8).
- MAX_BURST, 16, maximum consecutive transfers per grant before forced rotation (1..255).
- RD_LAT, 1, memory read latency in cycles from address presented to memory_read_data valid (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-engine access request, held while the engine has transfers pending.
- we_in  in  NUM_REQ  per-engine write enable (1 = write, 0 = read).
- addr_in  in  NUM_REQ*16  per-engine word address; engine i uses bits [16i+15:16i].
- wdata_in  in  NUM_REQ*32  per-engine write data; engine i uses bits [32i+31:32i].
- gnt  out  NUM_REQ  one-hot or zero grant.
- rvalid  out  NUM_REQ  read data valid for engine i.
- rdata_out  out  32  read data, broadcast to all engines; qualified by rvalid.
- memory_clk  out  1  equals clk.
- memory_addr  out  16  memory word address.
- memory_write_data  out  32  memory write data.
- enable_write  out  1  memory write strobe.
- memory_read_data  in  32  memory read data.
- busy  out  1  high while any grant is held.

Behaviour:
- Reset:
  - gnt=0, rvalid=0, busy=0, enable_write=0, memory_addr=0, memory_write_data=0.
  - Owner pointer = NUM_REQ-1, so requester 0 wins first.
  - Burst counter = 0, read-tag pipeline cleared.
  - Reset mid-burst drops in-flight reads; no rvalid is produced for them.
- FSM states:
  - IDLE: gnt=0, busy=0. If any req is high, the next cycle enters OWN with gnt[w] registered high, where w is the first requesting index searching round-robin from owner+1. Burst counter = 0.
  - OWN(k): gnt[k]=1, busy=1.
- Transfers:
  - A transfer occurs in any cycle with req[k]&gnt[k].
  - memory_addr, memory_write_data and enable_write are combinational muxes of requester k's inputs in that cycle. enable_write = we_in[k]&req[k]&gnt[k].
  - Outside a transfer: enable_write=0, memory_addr=0, memory_write_data=0.
- Release from OWN(k) is evaluated in each cycle. Release occurs when either:
  - req[k]=0 (no transfer that cycle), or
  - a transfer brings the burst counter to MAX_BURST.
- Handoff on release:
  - The winner w is picked round-robin from k+1 using current req; k itself is considered last.
  - If a winner exists, the next cycle is OWN(w) with the counter reset. This is a zero-bubble handoff.
  - Otherwise the next cycle is IDLE.
- Re-grant: a requester released by burst limit with req still high is re-granted only after all other pending requesters have had a turn. If it is the only requester, it is re-granted the next cycle.
- Reads:
  - Each read transfer (we_in[k]=0) pushes tag k into an RD_LAT-deep shift pipeline.
  - Exactly RD_LAT cycles later, rvalid[k]=1 for one cycle and rdata_out=memory_read_data.
  - Writes push an empty slot.
  - Reads are pipelined back-to-back: one per cycle, in issue order, including across handoffs.
- rdata_out is a passthrough of memory_read_data; it is 0-qualified only by rvalid.
- gnt changes only on clock edges; it is never multi-hot.

Optional Feature:
- SHA_ARB_FIXED_PRIO_EN:
  - Defined: the winner on any release/IDLE decision is the lowest-index requesting engine (req[0] highest priority). Burst locking and MAX_BURST still apply, so a lower-priority owner finishes its burst before preemption.
  - Undefined: round-robin as above.

Test Plan:
- Single requester, RD_LAT=1: req[0]=1 reads addr 0x0010..0x001F, 16 cycles.
  - gnt[0] one cycle after req.
  - memory_addr follows 0x0010..0x001F.
  - rvalid[0] lags each address by 1 cycle with the matching data.
  - Grant released after the 16th transfer.
- Contention: req[0], req[2] both held, 40 reads each, MAX_BURST=16.
  - Grants alternate 0,2,0,2,0,2 in bursts of 16,16,16,16,8,8 with no idle cycle between grants.
  - rvalid tags are correct across every handoff.
- Digest write: req[1] with we_in[1]=1 writes 8 words to 0x0100..0x0107.
  - enable_write high for exactly 8 cycles with the correct addr/data.
  - No rvalid pulse.
- Early drop: owner 3 deasserts req after 5 transfers while req[0] is pending.
  - gnt[0] the following cycle.
  - Burst counter restarts at 0.
- Reset mid-burst: assert rst_n=0 during a read burst with RD_LAT=3.
  - All outputs zero immediately.
  - No rvalid after release.
  - First grant after reset goes to requester 0.
- With SHA_ARB_FIXED_PRIO_EN and req[0], req[1] continuously high, MAX_BURST=4.
  - gnt[0] bursts of 4 with immediate re-grant.
  - gnt[1] never asserted.

Source files
------------

// File: rtl/sha256_mem_arbiter.sv
// sha256_mem_arbiter: burst-locked round-robin arbiter sharing one memory
// port among SHA-256 engines. Define SHA_ARB_FIXED_PRIO_EN for fixed priority.
module sha256_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      we_in,
  input  logic [NUM_REQ*16-1:0]   addr_in,
  input  logic [NUM_REQ*32-1:0]   wdata_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rvalid,
  output logic [31:0]             rdata_out,
  output logic                    memory_clk,
  output logic [15:0]             memory_addr,
  output logic [31:0]             memory_write_data,
  output logic                    enable_write,
  input  logic [31:0]             memory_read_data,
  output logic                    busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] sel;
  logic               xfer;
  logic               rd_xfer;
  logic               rel;
  logic               win_ok;
  logic [IW-1:0]      win;
  logic [IW-1:0]      lo;
  logic [IW-1:0]      hi;
  logic               any_lo;
  logic               any_hi;
  logic [RD_LAT-1:0]  rd_v;
  logic [IW-1:0]      rd_tag [RD_LAT];

  assign memory_clk = clk;
  assign rdata_out  = memory_read_data;
  assign sel        = req & gnt;
  assign xfer       = |sel;
  assign rd_xfer    = |(sel & ~we_in);
  assign rel        = !xfer || (cnt == CW'(MAX_BURST - 1));

  // Route the owner's request onto the memory bus only while it transfers
  always_comb begin
    memory_addr       = '0;
    memory_write_data = '0;
    enable_write      = 1'b0;
    if (xfer) begin
      memory_addr       = addr_in[{owner, 4'b0} +: 16];
      memory_write_data = wdata_in[{owner, 5'b0} +: 32];
      enable_write      = |(sel & we_in);
    end
  end

  // Winner search: lowest requester above owner, else lowest overall
  always_comb begin
    any_lo = 1'b0;
    any_hi = 1'b0;
    lo     = '0;
    hi     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_lo = 1'b1;
        lo     = IW'(i);
      end
      if (req[i] && (IW'(i) > owner)) begin
        any_hi = 1'b1;
        hi     = IW'(i);
      end
    end
    win_ok = any_lo;
`ifdef SHA_ARB_FIXED_PRIO_EN
    win = lo;
`else
    win = any_hi ? hi : lo;
`endif
  end

  // Ownership FSM with registered grant and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= IW'(NUM_REQ - 1);
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            state <= OWN;
            owner <= win;
            cnt   <= '0;
            gnt   <= NUM_REQ'(1) << win;
            busy  <= 1'b1;
          end
        end
        OWN: begin
          if (rel) begin
            cnt <= '0;
            if (win_ok) begin
              owner <= win;
              gnt   <= NUM_REQ'(1) << win;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Read-tag shift pipeline aligned with the memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_tag[i] <= '0;
    end else begin
      rd_v[0]   <= rd_xfer;
      rd_tag[0] <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_v[i]   <= rd_v[i-1];
        rd_tag[i] <= rd_tag[i-1];
      end
    end
  end

  // Decode the pipeline tail into a per-engine valid strobe
  always_comb begin
    rvalid = '0;
    if (rd_v[RD_LAT-1]) rvalid[rd_tag[RD_LAT-1]] = 1'b1;
  end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// tb_sha256_mem_arbiter: engine models drive the arbiter; reads are
// scoreboarded, grant bursts are recorded and compared with tables.
module tb_sha256_mem_arbiter;

  localparam int NR = 4;
  localparam int RL = 1;
`ifdef SHA_ARB_FIXED_PRIO_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    we_in = '0;
  logic [63:0]   addr_in = '0;
  logic [127:0]  wdata_in = '0;
  logic [3:0]    gnt, rvalid;
  logic [31:0]   rdata_out, memory_write_data, memory_read_data;
  logic [15:0]   memory_addr;
  logic          memory_clk, enable_write, busy;

  logic [3:0]    g3, rv3;
  logic [31:0]   rd3, mw3;
  logic [31:0]   mrd3 = 32'h0;
  logic [15:0]   ma3;
  logic          mclk3, we3, busy3;

  sha256_mem_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .RD_LAT(RL)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we_in(we_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt),
    .rvalid(rvalid), .rdata_out(rdata_out), .memory_clk(memory_clk),
    .memory_addr(memory_addr), .memory_write_data(memory_write_data),
    .enable_write(enable_write), .memory_read_data(memory_read_data),
    .busy(busy));

  sha256_mem_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .we_in(we_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(g3),
    .rvalid(rv3), .rdata_out(rd3), .memory_clk(mclk3),
    .memory_addr(ma3), .memory_write_data(mw3),
    .enable_write(we3), .memory_read_data(mrd3),
    .busy(busy3));

  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic logic [31:0] wdat(logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  logic [15:0] apipe = '0;
  always @(posedge clk) apipe <= memory_addr;
  assign memory_read_data = mdat(apipe);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t         sb[$];
  rd_t         e;
  logic [15:0] segs[$];
  logic [15:0] eseg[$];

  int          rem[NR];
  logic [15:0] base[NR];
  logic [15:0] ofs[NR];
  bit          wr[NR];
  bit          xf[NR];

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_rv = 0;
  int idle_pend = 0;
  bit chk3 = 1'b0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i]              = rem[i] > 0;
      we_in[i]            = wr[i];
      addr_in[16*i +: 16] = base[i] + ofs[i];
      wdata_in[32*i +: 32] = wdat(base[i] + ofs[i]);
    end
  endtask

  task automatic start(int i, int n, logic [15:0] b, bit w);
    rem[i]  = n;
    base[i] = b;
    ofs[i]  = '0;
    wr[i]   = w;
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (xf[i]) begin
        rem[i]--;
        ofs[i]++;
      end
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int b = 0;
    while (pending() && b < 600) begin
      step();
      b++;
    end
    if (b >= 600) check("timeout", 1, 0);
  endtask

  task automatic drain();
    repeat (5) step();
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic clear_stats();
    n_wr = 0;
    n_rv = 0;
    idle_pend = 0;
    segs.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      ofs[i] = '0;
      wr[i]  = 1'b0;
      xf[i]  = 1'b0;
    end
    drive();
    sb.delete();
    clear_stats();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_segs(string tag, logic [15:0] exp[$]);
    check({tag, "_n"}, segs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < segs.size(); i++)
      check(tag, segs[i], exp[i]);
  endtask

  // Per-cycle bus, grant and read-return checks
  always @(negedge clk) begin
    int k;
    logic [15:0] a;
    k = -1;
    for (int i = 0; i < NR; i++) begin
      xf[i] = rst_n && req[i] && gnt[i];
      if (xf[i]) k = i;
    end
    if (rst_n) begin
      if (chk3) check("r3_no_rv", rv3, 0);
      if (rvalid != 0) begin
        n_rv++;
        if (sb.size() == 0) check("rv_spurious", rvalid, 0);
        else begin
          e = sb.pop_front();
          check("rv_tag", rvalid, 4'b1 << e.tag);
          check("rv_data", rdata_out, e.data);
          check("rv_time", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rv_missing", rvalid, 4'b1 << e.tag);
      end
      check("onehot", $onehot0(gnt), 1);
      check("busy", busy, |gnt);
      if (gnt == 0 && req != 0) idle_pend++;
      if (k >= 0) begin
        a = base[k] + ofs[k];
        check("maddr", memory_addr, a);
        check("mwe", enable_write, wr[k]);
        if (wr[k]) begin
          check("mwdata", memory_write_data, wdat(a));
          n_wr++;
        end else begin
          sb.push_back('{tag: k, data: mdat(a), due: cyc + RL});
        end
        if (segs.size() == 0 || segs[segs.size()-1][15:12] != 4'(k))
          segs.push_back({4'(k), 12'd1});
        else
          segs[segs.size()-1] = segs[segs.size()-1] + 16'd1;
      end else begin
        check("bus_idle", {enable_write, memory_addr, memory_write_data}, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; base[i] = '0; ofs[i] = '0; wr[i] = 1'b0; xf[i] = 1'b0;
    end
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_we", enable_write, 0);
    check("rst_addr", memory_addr, 0);
    check("rst_wdata", memory_write_data, 0);

    // single requester, 16 reads
    do_reset();
    start(0, 16, 16'h0010, 1'b0);
    step();
    check("t1_gnt_lat", gnt, 4'b0001);
    wait_idle();
    step();
    check("t1_release", gnt, 0);
    drain();
    eseg = {16'h0010};
    check_segs("t1_seg", eseg);

    // contention between engines 0 and 2
    do_reset();
    start(0, 40, 16'h1000, 1'b0);
    start(2, 40, 16'h2000, 1'b0);
    wait_idle();
    drain();
`ifdef SHA_ARB_FIXED_PRIO_EN
    eseg = {16'h0028, 16'h2028};
`else
    eseg = {16'h0010, 16'h2010, 16'h0010, 16'h2010, 16'h0008, 16'h2008};
`endif
    check_segs("t2_seg", eseg);
    check("t2_idle_gap", idle_pend, 1);

    // digest write burst
    do_reset();
    start(1, 8, 16'h0100, 1'b1);
    wait_idle();
    drain();
    check("t3_we_cnt", n_wr, 8);
    check("t3_rv_cnt", n_rv, 0);
    eseg = {16'h1008};
    check_segs("t3_seg", eseg);

    // owner 3 drops early while 0 and 1 wait
    do_reset();
    start(3, 5, 16'h3000, 1'b0);
    step();
    start(0, 20, 16'h0040, 1'b0);
    start(1, 4, 16'h0180, 1'b1);
    for (int b = 0; b < 50 && rem[3] > 0; b++) step();
    step();
    check("t4_handoff", gnt, 4'b0001);
    wait_idle();
    drain();
`ifdef SHA_ARB_FIXED_PRIO_EN
    eseg = {16'h3005, 16'h0014, 16'h1004};
`else
    eseg = {16'h3005, 16'h0010, 16'h1004, 16'h0004};
`endif
    check_segs("t4_seg", eseg);

    // engines 0 and 1 held together
    do_reset();
    start(0, 24, 16'h0400, 1'b0);
    start(1, 4, 16'h0500, 1'b0);
    wait_idle();
    drain();
`ifdef SHA_ARB_FIXED_PRIO_EN
    eseg = {16'h0018, 16'h1004};
`else
    eseg = {16'h0010, 16'h1004, 16'h0008};
`endif
    check_segs("t5_seg", eseg);
    check("t5_idle_gap", idle_pend, 1);

    // reset in the middle of a read burst
    do_reset();
    start(0, 16, 16'h0600, 1'b0);
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    check("t6_g3", g3, 0);
    check("t6_rv3", rv3, 0);
    check("t6_busy3", busy3, 0);
    check("t6_bus3", {we3, ma3, mw3}, 0);
    check("t6_gnt", gnt, 0);
    check("t6_rv", rvalid, 0);
    do_reset();
    chk3 = 1'b1;
    repeat (6) step();
    chk3 = 1'b0;
    check("t6_no_rv", n_rv, 0);
    start(0, 1, 16'h0700, 1'b0);
    start(1, 1, 16'h0710, 1'b0);
    start(2, 1, 16'h0720, 1'b0);
    start(3, 1, 16'h0730, 1'b0);
    step();
    check("t6_first_g", gnt, 4'b0001);
    check("t6_first_g3", g3, 4'b0001);
    wait_idle();
    drain();
    eseg = {16'h0001, 16'h1001, 16'h2001, 16'h3001};
    check_segs("t6_seg", eseg);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
